fifo_stream: RTL and testbench
==============================

Name: fifo_stream

Overview:
Parametrised synchronous FIFO, successor to the team's plain wr_en/rd_en FIFO. Adds a valid/ready stream interface on both sides and a FWFT/standard read-mode select. Also adds programmable almost-full/almost-empty thresholds, a synchronous flush and a high-water-mark monitor. Used as the general buffering element between pipeline stages on the 32-bit datapath.

Parameters:
- DATA_WIDTH, 32, payload width in bits.
- DEPTH, 16, number of entries; power of two, >= 2.
- FWFT, 1, read mode: 1 = first-word-fall-through; 0 = standard, m_ready is a read request with 1-cycle latency.
- CW, $clog2(DEPTH)+1, derived; width of count, thresholds and hwm. Not to be overridden.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: reset, synchronous, active-high.
- flush, in, 1: synchronous clear of contents; priority below rst.
- s_data, in, DATA_WIDTH: write payload.
- s_valid, in, 1: write request.
- s_ready, out, 1: space available; a push occurs when s_valid && s_ready.
- m_data, out, DATA_WIDTH: read payload.
- m_valid, out, 1: m_data is valid.
- m_ready, in, 1: consumer accept (FWFT=1) or read request (FWFT=0).
- af_thresh, in, CW: almost-full threshold.
- ae_thresh, in, CW: almost-empty threshold.
- count, out, CW: current occupancy, 0..DEPTH.
- almost_full, out, 1: count >= af_thresh.
- almost_empty, out, 1: count <= ae_thresh.
- hwm, out, CW: maximum occupancy since last clear.
- hwm_clr, in, 1: load hwm with the current count.

Behaviour:
- Reset (rst=1 at an edge):
  - Pointers, count, hwm and m_valid go to 0; m_data goes to 0.
  - Memory contents are not cleared.
  - s_ready = 0 while rst is high.
  - After reset: almost_empty = 1; almost_full = (af_thresh == 0).
- s_ready = !rst && !flush && (count < DEPTH). It is combinational from registered state. There is no write-through-when-full: a pop in the same cycle does not free space for that cycle's push.
- Push: at the edge, mem[wr_ptr] <= s_data and wr_ptr increments, wrapping modulo DEPTH.
- FWFT=1 pop rules:
  - m_valid = (count != 0).
  - m_data = mem[rd_ptr] when m_valid, else forced to 0.
  - A pop occurs when m_valid && m_ready; rd_ptr then increments.
  - m_data is stable while m_valid && !m_ready.
  - A word pushed into an empty FIFO at edge N is visible with m_valid=1 after edge N, i.e. 1-cycle latency. There is no same-cycle bypass.
- FWFT=0 pop rules:
  - A pop occurs when m_ready && count != 0. At that edge, m_data <= mem[rd_ptr] and m_valid <= 1; m_valid is a single-cycle pulse.
  - Otherwise m_valid <= 0 and m_data holds its previous value.
  - m_ready with count == 0 is ignored (underflow-safe).
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Push and pop in the same cycle at count 1..DEPTH-1: both occur and count is unchanged.
  - Push is refused at count == DEPTH.
  - Pop is impossible at count == 0.
- almost_full and almost_empty are combinational compares against registered count. Thresholds may change at any time and take effect the same cycle. A threshold of 0 is legal.
- hwm update at each edge:
  - Without hwm_clr: hwm <= max(hwm, next_count).
  - With hwm_clr: hwm <= next_count.
  - hwm_clr is also honoured during a flush cycle, and flush does not otherwise clear hwm.
- Flush (flush=1 at an edge, rst=0):
  - wr_ptr, rd_ptr and count go to 0; m_valid goes to 0.
  - Any push or pop in that cycle is discarded.
  - In FWFT=0 mode, m_data holds its value.
  - Operation resumes the following cycle.
- Reset mid-operation: same as the reset state. No partial transfer completes in the rst cycle.

Decomposition:
- Shared package fifo_pkg holds:
  - the clog2-based width helper (CW derivation);
  - the read-mode constants FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1;
  - the legality check (DEPTH is a power of two and >= 2), which fails elaboration if violated.
- Sub-module fifo_ram: DEPTH x DATA_WIDTH storage with one synchronous write port and one asynchronous read port. It has no reset. fifo_stream contains the pointers, count, flags, hwm and the mode-dependent output logic.

Test Plan:
1. FWFT=1, DEPTH=16: push 0xA0..0xAF back-to-back with m_ready=0.
   - count reaches 16, s_ready=0 after the 16th push.
   - A 17th s_valid is not accepted.
   - m_data = 0xA0 throughout; then m_ready=1 drains 0xA0..0xAF in order, one per cycle.
2. Pointer wrap: 24 words in total, with sustained simultaneous push and pop at count=8.
   - count stays 8.
   - The output sequence matches the input exactly.
   - The pointer wrap is crossed without loss.
3. FWFT=0: push 0x11 and 0x22, then pulse m_ready for 1 cycle.
   - Next cycle: m_valid=1, m_data=0x11.
   - Following cycle: m_valid=0, m_data stays 0x11.
   - m_ready at count 0 produces no m_valid and count stays 0.
4. Thresholds af_thresh=12, ae_thresh=3: fill from 0 to 16.
   - almost_empty is 1 for count <= 3 and drops at count 4.
   - almost_full rises at count 12.
   - With af_thresh=0, almost_full=1 while empty.
5. Flush and hwm: fill to 10, pulse flush with s_valid=1 and m_ready=1 in the same cycle.
   - Next cycle: count=0, m_valid=0, hwm=10.
   - Refill to 5: hwm stays 10.
   - Pulse hwm_clr: hwm becomes 5.
6. Mid-stream reset: rst asserted with count=7 during push and pop.
   - Next cycle: count=0, m_valid=0, m_data=0, hwm=0, s_ready=0 while rst is high.
   - The first push after release is read out first.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the stream FIFO: read-mode encoding, width helper
// and the depth legality check used at elaboration.
package fifo_pkg;

    typedef enum int {
        FIFO_MODE_STD  = 0,
        FIFO_MODE_FWFT = 1
    } fifo_mode_e;

    // Width of count/threshold/hwm: must represent 0..depth inclusive.
    function automatic int fifo_cw(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit fifo_depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous
// read port, no reset (contents survive rst and flush).
module fifo_ram #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 16,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_stream.sv
// Synchronous valid/ready FIFO with FWFT or standard read mode, programmable
// almost-full/almost-empty flags, synchronous flush and high-water mark.
module fifo_stream
    import fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 16,
    parameter  int FWFT       = 1,
    localparam int CW         = fifo_cw(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    input  logic [CW-1:0]         af_thresh,
    input  logic [CW-1:0]         ae_thresh,
    output logic [CW-1:0]         count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         hwm,
    input  logic                  hwm_clr
);

    localparam int            AW   = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    if (!fifo_depth_ok(DEPTH)) begin : g_bad_depth
        $error("fifo_stream: DEPTH must be a power of two and >= 2");
    end

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         next_count;
    logic [CW-1:0]         hwm_q;
    logic [CW-1:0]         hwm_next;
    logic [DATA_WIDTH-1:0] ram_rd;
    logic                  push;
    logic                  pop;

    // Space is judged on registered count only: a same-cycle pop never frees
    // room for a push when full.
    assign s_ready = !rst && !flush && (count_q < FULL);
    assign push    = s_valid && s_ready;
    // Identical in both modes: in FWFT m_valid is exactly (count != 0).
    assign pop     = m_ready && (count_q != '0);

    always_comb begin
        next_count = count_q;
        if (flush) begin
            next_count = '0;
        end else if (push && !pop) begin
            next_count = count_q + 1'b1;
        end else if (pop && !push) begin
            next_count = count_q - 1'b1;
        end
    end

    always_comb begin
        hwm_next = hwm_q;
        if (hwm_clr) begin
            hwm_next = next_count;
        end else if (next_count > hwm_q) begin
            hwm_next = next_count;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            hwm_q   <= '0;
        end else begin
            hwm_q <= hwm_next;
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count_q <= next_count;
            end
        end
    end

    fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_ram (
        .clk    (clk),
        .wr_en  (push),
        .wr_addr(wr_ptr),
        .wr_data(s_data),
        .rd_addr(rd_ptr),
        .rd_data(ram_rd)
    );

    if (FWFT == int'(FIFO_MODE_FWFT)) begin : g_fwft
        assign m_valid = (count_q != '0);
        assign m_data  = m_valid ? ram_rd : '0;
    end else begin : g_std
        logic                  m_valid_q;
        logic [DATA_WIDTH-1:0] m_data_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                m_valid_q <= 1'b0;
                m_data_q  <= '0;
            end else if (flush) begin
                m_valid_q <= 1'b0;
            end else begin
                m_valid_q <= pop;
                if (pop) begin
                    m_data_q <= ram_rd;
                end
            end
        end

        assign m_valid = m_valid_q;
        assign m_data  = m_data_q;
    end

    assign count        = count_q;
    assign hwm          = hwm_q;
    assign almost_full  = (count_q >= af_thresh);
    assign almost_empty = (count_q <= ae_thresh);

endmodule

// File: tb/tb_fifo_stream.sv
// Bench for fifo_stream: FWFT and standard-mode instances share one stimulus
// stream and are checked against a queue-based model plus fixed vectors.
module tb_fifo_stream;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          flush;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          m_ready;
    logic [CW-1:0] af_thresh;
    logic [CW-1:0] ae_thresh;
    logic          hwm_clr;

    logic          f_s_ready, f_m_valid, f_af, f_ae;
    logic [DW-1:0] f_m_data;
    logic [CW-1:0] f_count, f_hwm;
    logic          d_s_ready, d_m_valid, d_af, d_ae;
    logic [DW-1:0] d_m_data;
    logic [CW-1:0] d_count, d_hwm;

    int checks = 0;
    int errors = 0;

    fifo_stream #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .flush(flush),
        .s_data(s_data), .s_valid(s_valid), .s_ready(f_s_ready),
        .m_data(f_m_data), .m_valid(f_m_valid), .m_ready(m_ready),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .count(f_count), .almost_full(f_af), .almost_empty(f_ae),
        .hwm(f_hwm), .hwm_clr(hwm_clr)
    );

    fifo_stream #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .flush(flush),
        .s_data(s_data), .s_valid(s_valid), .s_ready(d_s_ready),
        .m_data(d_m_data), .m_valid(d_m_valid), .m_ready(m_ready),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .count(d_count), .almost_full(d_af), .almost_empty(d_ae),
        .hwm(d_hwm), .hwm_clr(hwm_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents as a queue, standard-mode output as a register.
    logic [DW-1:0] q[$];
    int            m_hwm = 0;
    bit            m_sv  = 1'b0;
    logic [DW-1:0] m_sd  = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit do_push;
        bit do_pop;
        int nc;
        if (rst) begin
            q.delete();
            m_hwm = 0;
            m_sv  = 1'b0;
            m_sd  = '0;
        end else if (flush) begin
            q.delete();
            m_sv = 1'b0;
            if (hwm_clr) m_hwm = 0;
        end else begin
            do_push = s_valid && (q.size() < DEPTH);
            do_pop  = m_ready && (q.size() > 0);
            if (do_pop) begin
                m_sd = q.pop_front();
                m_sv = 1'b1;
            end else begin
                m_sv = 1'b0;
            end
            if (do_push) q.push_back(s_data);
            nc = q.size();
            m_hwm = hwm_clr ? nc : ((nc > m_hwm) ? nc : m_hwm);
        end
    endtask

    task automatic model_check();
        int n;
        n = q.size();
        chk("count_fwft", f_count, n);
        chk("count_std", d_count, n);
        chk("s_ready_fwft", f_s_ready, (!rst && !flush && n < DEPTH));
        chk("s_ready_std", d_s_ready, (!rst && !flush && n < DEPTH));
        chk("almost_full", f_af, (n >= int'(af_thresh)));
        chk("almost_empty", f_ae, (n <= int'(ae_thresh)));
        chk("almost_full_std", d_af, (n >= int'(af_thresh)));
        chk("hwm_fwft", f_hwm, m_hwm);
        chk("hwm_std", d_hwm, m_hwm);
        chk("m_valid_fwft", f_m_valid, (n > 0));
        chk("m_data_fwft", f_m_data, (n > 0) ? q[0] : '0);
        chk("m_valid_std", d_m_valid, m_sv);
        chk("m_data_std", d_m_data, m_sd);
    endtask

    // Inputs are held across the edge; outputs are sampled 1 ns after it.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic idle();
        s_valid = 1'b0;
        m_ready = 1'b0;
        flush   = 1'b0;
        hwm_clr = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push_n(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = base + DW'(i);
            tick();
        end
        s_valid = 1'b0;
    endtask

    typedef struct {
        bit            sv;
        logic [DW-1:0] sd;
        bit            mr;
        bit            fl;
        int            cnt;
        bit            fv;
        logic [DW-1:0] fd;
        bit            dv;
        logic [DW-1:0] dd;
    } vec_t;

    vec_t vt[10];

    initial begin
        rst = 1'b1; s_data = '0; af_thresh = CW'(12); ae_thresh = CW'(3);
        idle();

        // Reset state
        do_reset();
        chk("rst_count", f_count, 0);
        chk("rst_almost_empty", f_ae, 1);
        chk("rst_std_m_data", d_m_data, 0);

        // Fill to full with m_ready low; thresholds 12/3
        for (int i = 0; i < DEPTH; i++) begin
            s_valid = 1'b1;
            s_data  = 32'hA0 + DW'(i);
            tick();
            chk("fill_count", f_count, i + 1);
            chk("fill_ae", f_ae, (i + 1 <= 3));
            chk("fill_af", f_af, (i + 1 >= 12));
            chk("fill_head", f_m_data, 32'hA0);
        end
        chk("full_s_ready", f_s_ready, 0);
        s_data = 32'hBB;
        tick();
        chk("overflow_count", f_count, 16);
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_data", f_m_data, 32'hA0 + i);
            tick();
        end
        chk("drain_empty", f_m_valid, 0);
        m_ready   = 1'b0;
        af_thresh = '0;
        #1;
        chk("af_zero_empty", f_af, 1);
        af_thresh = CW'(12);

        // Pointer wrap with sustained push+pop at count 8
        do_reset();
        push_n(8, 32'h100);
        for (int k = 0; k < 16; k++) begin
            s_valid = 1'b1;
            s_data  = 32'h108 + DW'(k);
            m_ready = 1'b1;
            #1;
            chk("wrap_data", f_m_data, 32'h100 + k);
            tick();
            chk("wrap_count", f_count, 8);
        end
        s_valid = 1'b0;
        for (int k = 16; k < 24; k++) begin
            chk("wrap_tail", f_m_data, 32'h100 + k);
            tick();
        end
        chk("wrap_empty", f_count, 0);
        m_ready = 1'b0;

        // Fixed vectors: standard-mode latency, underflow, flush hold
        vt[0] = '{1'b1, 32'h11, 1'b0, 1'b0, 1, 1'b1, 32'h11, 1'b0, 32'h00};
        vt[1] = '{1'b1, 32'h22, 1'b0, 1'b0, 2, 1'b1, 32'h11, 1'b0, 32'h00};
        vt[2] = '{1'b0, 32'h00, 1'b1, 1'b0, 1, 1'b1, 32'h22, 1'b1, 32'h11};
        vt[3] = '{1'b0, 32'h00, 1'b0, 1'b0, 1, 1'b1, 32'h22, 1'b0, 32'h11};
        vt[4] = '{1'b0, 32'h00, 1'b1, 1'b0, 0, 1'b0, 32'h00, 1'b1, 32'h22};
        vt[5] = '{1'b0, 32'h00, 1'b1, 1'b0, 0, 1'b0, 32'h00, 1'b0, 32'h22};
        vt[6] = '{1'b1, 32'h33, 1'b1, 1'b0, 1, 1'b1, 32'h33, 1'b0, 32'h22};
        vt[7] = '{1'b1, 32'h44, 1'b1, 1'b0, 1, 1'b1, 32'h44, 1'b1, 32'h33};
        vt[8] = '{1'b1, 32'h55, 1'b1, 1'b1, 0, 1'b0, 32'h00, 1'b0, 32'h33};
        vt[9] = '{1'b0, 32'h00, 1'b0, 1'b0, 0, 1'b0, 32'h00, 1'b0, 32'h33};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            s_valid = vt[i].sv;
            s_data  = vt[i].sd;
            m_ready = vt[i].mr;
            flush   = vt[i].fl;
            tick();
            chk("vec_count", f_count, vt[i].cnt);
            chk("vec_fwft_valid", f_m_valid, vt[i].fv);
            chk("vec_fwft_data", f_m_data, vt[i].fd);
            chk("vec_std_valid", d_m_valid, vt[i].dv);
            chk("vec_std_data", d_m_data, vt[i].dd);
        end
        idle();

        // Flush and high-water mark
        do_reset();
        push_n(10, 32'h200);
        flush = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
        tick();
        idle();
        chk("flush_count", f_count, 0);
        chk("flush_m_valid", f_m_valid, 0);
        chk("flush_hwm", f_hwm, 10);
        push_n(5, 32'h300);
        chk("refill_hwm", f_hwm, 10);
        hwm_clr = 1'b1;
        tick();
        hwm_clr = 1'b0;
        chk("hwm_clr", f_hwm, 5);

        // Reset during simultaneous push and pop
        do_reset();
        push_n(7, 32'h400);
        s_valid = 1'b1; m_ready = 1'b1; rst = 1'b1;
        tick();
        chk("midrst_count", f_count, 0);
        chk("midrst_m_valid", d_m_valid, 0);
        chk("midrst_m_data", d_m_data, 0);
        chk("midrst_hwm", f_hwm, 0);
        chk("midrst_s_ready", f_s_ready, 0);
        rst = 1'b0;
        idle();
        push_n(2, 32'h77);
        chk("post_rst_fwft", f_m_data, 32'h77);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("post_rst_std", d_m_data, 32'h77);

        // Randomised traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            s_valid = ($urandom_range(0, 99) < 60);
            s_data  = $urandom;
            m_ready = ($urandom_range(0, 99) < 55);
            flush   = ($urandom_range(0, 63) == 0);
            hwm_clr = ($urandom_range(0, 31) == 0);
            rst     = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0) begin
                af_thresh = CW'($urandom_range(0, DEPTH + 1));
                ae_thresh = CW'($urandom_range(0, DEPTH + 1));
            end
            tick();
        end
        rst = 1'b0;
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
